// File: rtl/prescaled_updown_counter.sv
// Up/down counter that steps once every PRESCALE enabled clocks, with a programmable
// modulus, synchronous clear/load, and wrap or saturate behaviour at the range ends.
module prescaled_updown_counter #(
    parameter int DATA_WIDTH = 4,
    parameter int PRESCALE   = 50000000,
    parameter int MAX_COUNT  = 2**DATA_WIDTH-1,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  direction,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  tick,
    output logic                  wrap,
    output logic                  terminal
);

    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0]      PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam logic [PSC_W-1:0]      PSC_ONE  = PSC_W'(1);
    localparam logic [DATA_WIDTH-1:0] MAX_VAL  = DATA_WIDTH'(MAX_COUNT);
    localparam logic [DATA_WIDTH-1:0] ZERO     = '0;
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    logic [PSC_W-1:0] psc;
    logic             psc_last;
    logic             step;
    logic [DATA_WIDTH:0] stepped;

    // Returns {wrap_flag, next_count}; the range ends are MAX_VAL and 0, never 2^DATA_WIDTH.
    function automatic logic [DATA_WIDTH:0] step_count(input logic [DATA_WIDTH-1:0] cur,
                                                       input logic up);
        logic [DATA_WIDTH:0] r;
        r = {1'b0, cur};
        if (up) begin
            if (cur == MAX_VAL)
                r = (SATURATE != 0) ? {1'b0, MAX_VAL} : {1'b1, ZERO};
            else
                r = {1'b0, cur + ONE};
        end else begin
            if (cur == ZERO)
                r = (SATURATE != 0) ? {1'b0, ZERO} : {1'b1, MAX_VAL};
            else
                r = {1'b0, cur - ONE};
        end
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] clamp(input logic [DATA_WIDTH-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    assign psc_last = (psc == PSC_LAST);
    assign step     = en && psc_last;
    assign stepped  = step_count(count, direction);
    assign terminal = direction ? (count == MAX_VAL) : (count == ZERO);

    // Prescaler: only advances while enabled; clear realigns the step phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
        end else if (clear) begin
            psc <= '0;
        end else if (en) begin
            psc <= psc_last ? '0 : psc + PSC_ONE;
        end
    end

    // Count and status pulses; with en low and no clear/load everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= clamp(load_value);
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (en) begin
            if (step) begin
                count <= stepped[DATA_WIDTH-1:0];
                tick  <= 1'b1;
                wrap  <= stepped[DATA_WIDTH];
            end else begin
                tick  <= 1'b0;
                wrap  <= 1'b0;
            end
        end
    end

endmodule
